// File: rtl/game_input_arbiter.sv
// Control-input front end: per-channel stability filter, fixed-priority or last-active
// ownership arbitration, registered command outputs, and end-game key pulse synchroniser.
// Optional hold-on-loss timeout is enabled by defining INPUT_TIMEOUT_EN.
module game_input_arbiter #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned CW          = 20
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NUM_CH-1:0]     ch_valid,
  input  logic [4*NUM_CH-1:0]   ch_cmd,
  input  logic                  mode,
  input  logic                  end_req_n,
  output logic                  forward,
  output logic                  backward,
  output logic [1:0]            turn,
  output logic                  cmd_valid,
  output logic [NUM_CH-1:0]     owner,
  output logic                  end_pulse
);

  localparam int unsigned CNTW = $clog2(HOLD_CYCLES + 1);

  logic [CNTW-1:0]   cnt_q [NUM_CH];
  logic [CNTW-1:0]   cnt_d [NUM_CH];
  logic [3:0]        cmd_q [NUM_CH];
  logic [3:0]        cmd_d [NUM_CH];
  logic [NUM_CH-1:0] qual_q, qual_d, qual_prev_q;
  logic [NUM_CH-1:0] rise_c;
  logic [NUM_CH-1:0] owner_q, owner_d;
  logic [3:0]        own_cmd_c;
  logic [3:0]        out_q, out_d;
  logic              valid_q, valid_d;
  logic              sync1_q, sync2_q, hist_q, pulse_q;

  function automatic logic [NUM_CH-1:0] lowest(input logic [NUM_CH-1:0] v);
    logic [NUM_CH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (v[i] && (r == '0)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Stability filter: a channel qualifies after HOLD_CYCLES identical valid samples
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      cmd_d[i]  = cmd_q[i];
      if (!ch_valid[i]) begin
        cnt_d[i] = '0;
      end else if (ch_cmd[4*i +: 4] != cmd_q[i]) begin
        cmd_d[i] = ch_cmd[4*i +: 4];
        cnt_d[i] = CNTW'(1);
      end else if (cnt_q[i] != CNTW'(HOLD_CYCLES)) begin
        cnt_d[i] = cnt_q[i] + CNTW'(1);
      end
      qual_d[i] = (cnt_d[i] == CNTW'(HOLD_CYCLES));
    end
  end

  assign rise_c = qual_q & ~qual_prev_q;

  // Ownership: mode 0 fixed priority, mode 1 newest qualified channel wins
  always_comb begin
    owner_d = owner_q;
    if (!mode) begin
      owner_d = lowest(qual_q);
    end else if ((owner_q & qual_q) != '0) begin
      if ((rise_c & ~owner_q) != '0) owner_d = lowest(rise_c & ~owner_q);
    end else if (rise_c != '0) begin
      owner_d = lowest(rise_c);
    end else begin
      owner_d = lowest(qual_q);
    end
  end

  always_comb begin
    own_cmd_c = 4'b0000;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (owner_d[i]) own_cmd_c = cmd_q[i];
    end
  end

`ifdef INPUT_TIMEOUT_EN
  logic [CW-1:0] tmo_q, tmo_d;

  // Hold the last command for TIMEOUT cycles after ownership is lost
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    tmo_d   = tmo_q;
    if (owner_d != '0) begin
      out_d   = own_cmd_c;
      valid_d = 1'b1;
      tmo_d   = '0;
    end else if (tmo_q == CW'(TIMEOUT)) begin
      out_d   = 4'b0000;
      valid_d = 1'b0;
      tmo_d   = '0;
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q + CW'(1);
    end else if (valid_q) begin
      tmo_d = CW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  logic unused_tmo_cfg_c;
  assign unused_tmo_cfg_c = ^CW'(TIMEOUT);

  always_comb begin
    out_d   = 4'b0000;
    valid_d = 1'b0;
    if (owner_d != '0) begin
      out_d   = own_cmd_c;
      valid_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        cmd_q[i] <= '0;
      end
      qual_q      <= '0;
      qual_prev_q <= '0;
      owner_q     <= '0;
      out_q       <= 4'b0000;
      valid_q     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        cmd_q[i] <= cmd_d[i];
      end
      qual_q      <= qual_d;
      qual_prev_q <= qual_q;
      owner_q     <= owner_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
    end
  end

  // End-game key: two-flop synchroniser, history flop, registered falling-edge pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= end_req_n;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      pulse_q <= hist_q & ~sync2_q;
    end
  end

  assign forward   = out_q[3];
  assign backward  = out_q[2];
  assign turn      = out_q[1:0];
  assign cmd_valid = valid_q;
  assign owner     = owner_q;
  assign end_pulse = pulse_q;

endmodule
